// File: rtl/ifetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_queue_pkg
// Shared definitions for the instruction fetch queue:
//   XLEN / ILEN       address and instruction widths
//   RESET_PC_DEFAULT  default fetch address after reset
//   fetch_entry_t     one buffered fetch result {inst, pc, err}
//   word_align()      forces an address onto a 4-byte boundary
// ---------------------------------------------------------------------------
package ifetch_queue_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

   typedef struct packed {
      logic [ILEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic            err;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ---------------------------------------------------------------------------
// ifq_fifo
// Synchronous DEPTH-entry FIFO of fetch entries. Pointers wrap modulo DEPTH
// (DEPTH is a power of two). Storage is not reset; only pointers and the
// occupancy count are.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear          empties the FIFO; wins over push and pop
//   push, wr_entry write one entry (caller guarantees not full unless popping)
//   pop            remove the head entry (ignored when empty)
//   rd_entry       current head entry
//   occ            number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module ifq_fifo
   import ifetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   push,
   input  fetch_entry_t           wr_entry,
   input  logic                   pop,
   output fetch_entry_t           rd_entry,
   output logic [$clog2(DEPTH):0] occ
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] OCC_ONE = CW'(1);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push & ~clear;
   assign do_pop  = pop & (occ != '0) & ~clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
      end
   end

   // Data storage carries no reset; validity is tracked by occ alone.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

   assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
// Instruction fetch unit and queue feeding decode. Issues in-order word
// fetches with credit-based flow control (occupancy + outstanding never
// exceeds DEPTH, so every response has a FIFO slot), buffers responses and
// presents the head with its PC and fault flag. Flush (execute) and taken
// branch prediction (on the popped head) redirect fetch; responses still in
// flight at the redirect are counted in drop and discarded on arrival.
//
// Optional build macro IFQ_BYPASS_EN: a non-dropped response arriving while
// the FIFO is empty is shown on o_inst* in the same cycle; if decode takes it
// that cycle it is never written to the FIFO.
//
// Ports:
//   i_clk, i_rstn                         clock, async active-low reset
//   o_ibus_req_vld/i_ibus_req_rdy/addr    fetch request handshake
//   i_ibus_rsp_vld/data/err               in-order response, always accepted
//   i_flush, i_flush_pc                   execute redirect (highest priority)
//   i_bp_redirect, i_bp_pc                predictor redirect, only with pop
//   o_inst_vld/o_inst/o_inst_pc/o_inst_err head instruction to decode
//   i_inst_rdy                            decode accepts head
// ---------------------------------------------------------------------------
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   output logic            o_ibus_req_vld,
   input  logic            i_ibus_req_rdy,
   output logic [XLEN-1:0] o_ibus_req_addr,
   input  logic            i_ibus_rsp_vld,
   input  logic [ILEN-1:0] i_ibus_rsp_data,
   input  logic            i_ibus_rsp_err,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_flush_pc,
   input  logic            i_bp_redirect,
   input  logic [XLEN-1:0] i_bp_pc,
   output logic            o_inst_vld,
   output logic [ILEN-1:0] o_inst,
   output logic [XLEN-1:0] o_inst_pc,
   output logic            o_inst_err,
   input  logic            i_inst_rdy
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [CW-1:0]   occ;
   logic [CW-1:0]   outst;
   logic [CW-1:0]   outst_nxt;
   logic [CW-1:0]   drop;
   logic [CW:0]     credit_used;

   logic            pop;
   logic            redir;
   logic            req_fire;
   logic            rsp_ok;
   logic            accept;
   logic            push;
   logic            byp;
   logic [XLEN-1:0] target;
   fetch_entry_t    wr_entry;
   fetch_entry_t    head;
   fetch_entry_t    shown;

   assign credit_used = {1'b0, occ} + {1'b0, outst};
   assign target      = i_flush ? word_align(i_flush_pc) : word_align(i_bp_pc);

   // A response is usable unless it is stale (drop) or a flush discards it.
   // The predictor redirect is folded in later through accept, which keeps
   // the bypass valid free of a loop through pop.
   assign rsp_ok = i_rstn & i_ibus_rsp_vld & ~i_flush & (drop == '0);

`ifdef IFQ_BYPASS_EN
   assign byp = rsp_ok & (occ == '0);
`else
   assign byp = 1'b0;
`endif

   assign o_inst_vld = (occ != '0) | byp;
   assign pop        = o_inst_vld & i_inst_rdy;
   assign redir      = i_flush | (i_bp_redirect & pop);
   assign accept     = rsp_ok & ~redir;
   assign push       = accept & ~(byp & pop);

   // Gated by i_rstn so no request is shown while reset is held.
   assign o_ibus_req_vld  = i_rstn & (credit_used < CREDITS) & ~redir;
   assign req_fire        = o_ibus_req_vld & i_ibus_req_rdy;
   assign o_ibus_req_addr = fetch_pc;

   always_comb begin
      wr_entry      = '0;
      wr_entry.inst = i_ibus_rsp_data;
      wr_entry.pc   = rsp_pc;
      wr_entry.err  = i_ibus_rsp_err;
   end

   always_comb begin
      outst_nxt = outst;
      if (req_fire && !i_ibus_rsp_vld) begin
         outst_nxt = outst + CNT_ONE;
      end else if (!req_fire && i_ibus_rsp_vld) begin
         outst_nxt = outst - CNT_ONE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         outst    <= '0;
         drop     <= '0;
      end else begin
         outst <= outst_nxt;
         if (redir) begin
            fetch_pc <= target;
            rsp_pc   <= target;
            // Everything still in flight after this cycle's response is stale.
            drop     <= outst_nxt;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (accept)   rsp_pc   <= rsp_pc + 32'd4;
            if (i_ibus_rsp_vld && (drop != '0)) drop <= drop - CNT_ONE;
         end
      end
   end

   ifq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (i_clk),
      .rst_n    (i_rstn),
      .clear    (redir),
      .push     (push),
      .wr_entry (wr_entry),
      .pop      (pop),
      .rd_entry (head),
      .occ      (occ)
   );

   always_comb begin
      shown = head;
`ifdef IFQ_BYPASS_EN
      if (byp) shown = wr_entry;
`endif
   end

   // Unreset FIFO storage is masked so outputs read zero while nothing is valid.
   always_comb begin
      o_inst     = '0;
      o_inst_pc  = '0;
      o_inst_err = 1'b0;
      if (o_inst_vld) begin
         o_inst     = shown.inst;
         o_inst_pc  = shown.pc;
         o_inst_err = shown.err;
      end
   end

   credit_bound: assert property (@(posedge i_clk) disable iff (!i_rstn)
      credit_used <= CREDITS);

   rsp_has_request: assert property (@(posedge i_clk) disable iff (!i_rstn)
      i_ibus_rsp_vld |-> (outst != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

   localparam logic [31:0] KEY = 32'h1357_9BDF;
`ifdef IFQ_BYPASS_EN
   localparam int LAT = 0;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        req_vld;
   logic        req_rdy = 1'b1;
   logic [31:0] req_addr;
   logic        rsp_vld = 1'b0;
   logic [31:0] rsp_data = '0;
   logic        rsp_err = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        bp = 1'b0;
   logic [31:0] bp_pc = '0;
   logic        inst_vld;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_err;
   logic        inst_rdy = 1'b1;

   logic        rsp_en = 1'b1;
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   logic [31:0] pend_q[$];
   logic [31:0] bus_addr;

   int n_checks = 0;
   int n_errors = 0;

   ifetch_queue dut (
      .i_clk           (clk),
      .i_rstn          (rstn),
      .o_ibus_req_vld  (req_vld),
      .i_ibus_req_rdy  (req_rdy),
      .o_ibus_req_addr (req_addr),
      .i_ibus_rsp_vld  (rsp_vld),
      .i_ibus_rsp_data (rsp_data),
      .i_ibus_rsp_err  (rsp_err),
      .i_flush         (flush),
      .i_flush_pc      (flush_pc),
      .i_bp_redirect   (bp),
      .i_bp_pc         (bp_pc),
      .o_inst_vld      (inst_vld),
      .o_inst          (inst),
      .o_inst_pc       (inst_pc),
      .o_inst_err      (inst_err),
      .i_inst_rdy      (inst_rdy)
   );

   always #5 clk = ~clk;

   // Bus model: accepted request in cycle N answers in cycle N+1 (when enabled).
   always @(negedge clk) begin
      if (rstn && req_vld && req_rdy) pend_q.push_back(req_addr);
   end

   always @(posedge clk) begin
      #1;
      if (!rstn) begin
         pend_q.delete();
         rsp_vld = 1'b0;
      end else if (rsp_en && pend_q.size() > 0) begin
         bus_addr = pend_q.pop_front();
         rsp_vld  = 1'b1;
         rsp_data = bus_addr ^ KEY;
         rsp_err  = (bus_addr == err_addr);
      end else begin
         rsp_vld = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Returns at the negedge of the first cycle after reset release.
   task automatic do_reset(input logic rdy);
      @(posedge clk); #1;
      rstn = 1'b0; inst_rdy = rdy; flush = 1'b0; bp = 1'b0; req_rdy = 1'b1; rsp_en = 1'b1;
      @(negedge clk);
      check("rst_req_vld",  32'(req_vld),  32'd0);
      check("rst_req_addr", req_addr,      32'h8000_0000);
      check("rst_inst_vld", 32'(inst_vld), 32'd0);
      check("rst_inst",     inst,          32'd0);
      check("rst_inst_pc",  inst_pc,       32'd0);
      check("rst_inst_err", 32'(inst_err), 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_vld(input string tag, input logic [31:0] exp_pc);
      int n;
      n = 0;
      while (inst_vld !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_vld"}, 32'(inst_vld), 32'd1);
      check(tag, inst_pc, exp_pc);
   endtask

   initial begin
      // Streaming after reset: one request per cycle, PCs follow.
      do_reset(1'b1);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("seq_req_vld%0d", k), 32'(req_vld), 32'd1);
         check($sformatf("seq_req_addr%0d", k), req_addr, 32'h8000_0000 + 32'(4 * k));
         if (k < 1 + LAT) begin
            check($sformatf("seq_inst_vld%0d", k), 32'(inst_vld), 32'd0);
         end else begin
            check($sformatf("seq_inst_vld%0d", k), 32'(inst_vld), 32'd1);
            check($sformatf("seq_inst_pc%0d", k), inst_pc, 32'h8000_0000 + 32'(4 * (k - 1 - LAT)));
            if (k == 1 + LAT) check("seq_inst_word", inst, 32'h9357_9BDF);
         end
      end

      // Decode stalled: exactly DEPTH requests, then credits exhausted.
      do_reset(1'b0);
      begin
         int cnt;
         cnt = 0;
         for (int k = 0; k < 10; k++) begin
            if (req_vld && req_rdy) cnt++;
            @(negedge clk);
         end
         check("fill_req_count", 32'(cnt), 32'd4);
      end
      check("fill_req_vld",  32'(req_vld),  32'd0);
      check("fill_inst_vld", 32'(inst_vld), 32'd1);
      check("fill_inst_pc",  inst_pc,       32'h8000_0000);
      @(posedge clk); #1; inst_rdy = 1'b1;
      @(negedge clk);
      check("fill_pop_req_vld", 32'(req_vld), 32'd0);
      @(posedge clk); #1; inst_rdy = 1'b0;
      @(negedge clk);
      check("fill_after_req_vld",  32'(req_vld), 32'd1);
      check("fill_after_req_addr", req_addr,     32'h8000_0010);
      check("fill_after_inst_pc",  inst_pc,      32'h8000_0004);

      // Flush with three requests in flight.
      do_reset(1'b1);
      rsp_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1;
      req_rdy = 1'b0; flush = 1'b1; flush_pc = 32'h8000_1002;
      @(negedge clk);
      check("flush_req_vld", 32'(req_vld), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; req_rdy = 1'b1; rsp_en = 1'b1;
      @(negedge clk);
      check("flush_req_vld_next", 32'(req_vld), 32'd1);
      check("flush_req_addr",     req_addr,     32'h8000_1000);
      check("flush_inst_vld",     32'(inst_vld), 32'd0);
      wait_vld("flush_first_pc", 32'h8000_1000);

      // Predictor redirect: ignored without pop, taken with pop on 0x80000008.
      do_reset(1'b0);
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      bp = 1'b1; bp_pc = 32'h8000_0100;
      @(negedge clk);
      check("bp_nopop_pc",      inst_pc,      32'h8000_0000);
      check("bp_nopop_req_vld", 32'(req_vld), 32'd0);
      @(posedge clk); #1;
      bp = 1'b0; inst_rdy = 1'b1;
      @(negedge clk);
      check("bp_head0_vld", 32'(inst_vld), 32'd1);
      check("bp_head0_pc",  inst_pc,       32'h8000_0000);
      @(negedge clk);
      check("bp_head1_pc",  inst_pc,       32'h8000_0004);
      @(posedge clk); #1;
      bp = 1'b1;
      @(negedge clk);
      check("bp_head2_pc",  inst_pc,      32'h8000_0008);
      check("bp_req_vld",   32'(req_vld), 32'd0);
      @(posedge clk); #1;
      bp = 1'b0;
      @(negedge clk);
      check("bp_new_req_vld",  32'(req_vld),  32'd1);
      check("bp_new_req_addr", req_addr,      32'h8000_0100);
      check("bp_inst_vld",     32'(inst_vld), 32'd0);
      wait_vld("bp_first_pc", 32'h8000_0100);

      // Flush and predictor redirect together: flush target wins.
      do_reset(1'b0);
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      flush = 1'b1; flush_pc = 32'h8000_2000; bp = 1'b1; bp_pc = 32'h8000_0300; inst_rdy = 1'b1;
      @(negedge clk);
      check("both_inst_vld", 32'(inst_vld), 32'd1);
      check("both_req_vld",  32'(req_vld),  32'd0);
      @(posedge clk); #1;
      flush = 1'b0; bp = 1'b0;
      @(negedge clk);
      check("both_req_vld_next", 32'(req_vld), 32'd1);
      check("both_req_addr",     req_addr,     32'h8000_2000);
      wait_vld("both_first_pc", 32'h8000_2000);

      // Bus fault on 0x8000000C only.
      err_addr = 32'h8000_000C;
      do_reset(1'b0);
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      inst_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         else @(negedge clk);
         check($sformatf("err_pc%0d", k),  inst_pc,       32'h8000_0000 + 32'(4 * k));
         check($sformatf("err_flag%0d", k), 32'(inst_err), (k == 3) ? 32'd1 : 32'd0);
         if (k == 3) check("err_inst_word", inst, 32'h9357_9BD3);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch unit and queue that feeds the decode stage. Owns the fetch PC and issues in-order word requests on the instruction bus, using credit-based flow control so every response has a slot. Buffers responses in a small FIFO and presents them, with PC and error status, to the decoder's instruction input. Handles redirects from execute (flush) and from the branch predictor, discarding stale in-flight responses.

## Interface

- DEPTH, 4: FIFO entries, power of two, ≥2; also the maximum number of outstanding requests.
- RESET_PC, 32'h8000_0000: fetch address after reset.

- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- o_ibus_req_vld  out  1  fetch request valid
- i_ibus_req_rdy  in  1  bus accepts request
- o_ibus_req_addr  out  32  word-aligned fetch address
- i_ibus_rsp_vld  in  1  response valid, in request order, always accepted
- i_ibus_rsp_data  in  32  instruction word
- i_ibus_rsp_err  in  1  bus fault for this word
- i_flush  in  1  execute redirect (mispredict, trap)
- i_flush_pc  in  32  flush target; bits [1:0] ignored
- i_bp_redirect  in  1  predictor taken on the head instruction; qualified by pop
- i_bp_pc  in  32  predicted target; bits [1:0] ignored
- o_inst_vld  out  1  head instruction valid (drives decoder i_inst_vld)
- o_inst  out  32  head instruction word
- o_inst_pc  out  32  head PC
- o_inst_err  out  1  head carries a fetch fault
- i_inst_rdy  in  1  decode consumes head; pop = o_inst_vld & i_inst_rdy

## Operation

- State: fetch_pc, rsp_pc, FIFO (inst, pc, err), occ (0..DEPTH), outst (0..DEPTH), drop (0..DEPTH).
- Request: o_ibus_req_vld = (occ + outst < DEPTH) & ~redir, where redir = i_flush | (i_bp_redirect & pop). On req handshake: fetch_pc += 4, outst += 1.
- Response: outst -= 1. If drop > 0: discard, drop -= 1. Else push {data, rsp_pc, err} and rsp_pc += 4.
- Redirect: i_flush has priority over i_bp_redirect. Target = {target[31:2], 2'b00}. FIFO cleared (occ = 0), fetch_pc = rsp_pc = target, drop = outst after this cycle's response is counted. A response in the redirect cycle is always discarded.
- i_bp_redirect without pop is ignored.
- Credit rule guarantees push never occurs when full; simultaneous push and pop at full is legal.
- o_inst_err entries are presented normally; decode/execute handle the trap.
- All counters saturate-free by construction; an assertion flags occ + outst > DEPTH.

## Timing

- Reset: o_ibus_req_vld 0 during reset, o_ibus_req_addr = RESET_PC, o_inst_vld 0, o_inst 0, o_inst_pc 0, o_inst_err 0; occ = outst = drop = 0. First request is valid in the first cycle after deassertion.
- Response accepted in cycle N → o_inst_vld in N+1 (registered FIFO).
- Redirect in cycle N → o_ibus_req_vld with new address in N+1; o_inst_vld low in N+1 unless the bypass path applies.
- Reset mid-operation clears all state; the bus must also be reset, since in-flight responses are not tracked across reset.
- Steady state sustains one instruction per cycle when bus latency is at most DEPTH-1 cycles.

## Configuration

- IFQ_BYPASS_EN defined: when occ = 0 and the response is not dropped, the response drives o_inst* combinationally in the same cycle. If popped that cycle, it is not written to the FIFO. Latency is 0 cycles.
- Undefined: all outputs come from FIFO registers; latency is 1 cycle.

## Structure

- Shared package/defines: xlen/ilen widths, RESET_PC default, the fetch entry typedef {inst[31:0], pc[31:0], err}.
- One sub-module, ifq_fifo: synchronous DEPTH-entry FIFO with push, pop, clear, and occ output. Read/write pointers wrap modulo DEPTH.

## Test plan

- Reset release with zero-latency ready bus and i_inst_rdy=1 → requests to 0x80000000, 0x80000004, …; o_inst_pc follows one response later with the same sequence.
- i_inst_rdy=0, bus ready → exactly 4 requests issued, FIFO fills to occ=4, o_ibus_req_vld stays 0 until the first pop.
- 3 outstanding requests, i_flush with i_flush_pc=0x80001002 → next request addr 0x80001000; the 3 old responses are dropped; the first o_inst_pc is 0x80001000.
- Head at 0x80000008 popped with i_bp_redirect, i_bp_pc=0x80000100 → younger entries removed; next o_inst_pc is 0x80000100. The same redirect without pop has no effect.
- i_flush and i_bp_redirect with pop in the same cycle → i_flush_pc wins.
- Response with i_ibus_rsp_err=1 at 0x8000000C → o_inst_err=1 with o_inst_pc=0x8000000C; the following entry has err 0.
